// File: rtl/pio_bus_responder.sv
// Nios PIO register-bus responder: req/ack handshake to single-cycle core register strobes.
// Optional RESP_TXN_COUNT_EN adds completed-transaction counters readable locally at 8'hFE.
module pio_bus_responder #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned READ_TIMEOUT = 255,
    parameter logic [31:0] TIMEOUT_WORD = 32'hDEAD_BEEF,
    parameter logic [7:0]  CLR_ADDR     = 8'hFF
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [7:0]  address_export,
    input  logic [31:0] write_export,
    output logic [31:0] read_export,
    inout  wire  [7:0]  control_export,
    output logic [7:0]  core_addr,
    output logic [31:0] core_wdata,
    output logic        core_wr_en,
    output logic        core_rd_en,
    input  logic [31:0] core_rdata,
    input  logic        core_rd_valid,
    input  logic        core_busy,
    input  logic        core_done
);

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = (READ_TIMEOUT < 2) ? 1 : $clog2(READ_TIMEOUT + 1);
`ifdef RESP_TXN_COUNT_EN
    localparam int unsigned  NW       = 16;
    localparam logic [AW-1:0] CNT_ADDR = 8'hFE;
`endif

    typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT, ACK} state_t;

    state_t              state_q, state_d;
    logic [SYNC_STAGES-1:0] wr_sync_q, rd_sync_q;
    logic [AW-1:0]       core_addr_q, core_addr_d;
    logic [DW-1:0]       core_wdata_q, core_wdata_d;
    logic [DW-1:0]       read_export_q, read_export_d;
    logic                core_wr_en_q, core_wr_en_d;
    logic                core_rd_en_q, core_rd_en_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CW-1:0]       tmo_q, tmo_d;
    logic                clr_done;
    logic                local_rd;
    logic                wr_s, rd_s;
`ifdef RESP_TXN_COUNT_EN
    logic [NW-1:0]       wr_cnt_q, wr_cnt_d;
    logic [NW-1:0]       rd_cnt_q, rd_cnt_d;
`endif

    assign wr_s = wr_sync_q[SYNC_STAGES-1];
    assign rd_s = rd_sync_q[SYNC_STAGES-1];

    // Host-owned bits [3:0] are left undriven; status nibble is always driven.
    assign control_export[7:4] = {done_q, busy_q, err_q, ack_q};
    assign read_export = read_export_q;
    assign core_addr   = core_addr_q;
    assign core_wdata  = core_wdata_q;
    assign core_wr_en  = core_wr_en_q;
    assign core_rd_en  = core_rd_en_q;

    logic unused_ctrl;
    assign unused_ctrl = ^control_export[7:2];

    always_comb begin
        state_d       = state_q;
        core_addr_d   = core_addr_q;
        core_wdata_d  = core_wdata_q;
        read_export_d = read_export_q;
        err_d         = err_q;
        tmo_d         = tmo_q;
        clr_done      = 1'b0;
        local_rd      = 1'b0;
`ifdef RESP_TXN_COUNT_EN
        wr_cnt_d      = wr_cnt_q;
        rd_cnt_d      = rd_cnt_q;
        local_rd      = (address_export == CNT_ADDR);
`endif
        unique case (state_q)
            IDLE: begin
                if ((wr_s || rd_s) && !ack_q) begin
                    core_addr_d  = address_export;
                    core_wdata_d = write_export;
                    err_d        = 1'b0;
                    if (wr_s && rd_s) begin
                        err_d   = 1'b1;
                        state_d = ACK;
                    end else if (wr_s) begin
                        if (address_export == CLR_ADDR) begin
                            clr_done = 1'b1;
                            state_d  = ACK;
`ifdef RESP_TXN_COUNT_EN
                            wr_cnt_d = wr_cnt_q + NW'(1);
`endif
                        end else begin
                            state_d = WRITE;
                        end
                    end else begin
                        state_d = RD_ISSUE;
                    end
                end
            end
            WRITE: begin
                state_d = ACK;
`ifdef RESP_TXN_COUNT_EN
                wr_cnt_d = wr_cnt_q + NW'(1);
`endif
            end
            RD_ISSUE: begin
`ifdef RESP_TXN_COUNT_EN
                if (core_addr_q == CNT_ADDR) begin
                    // Value captured before this read is counted.
                    read_export_d = {wr_cnt_q, rd_cnt_q};
                    rd_cnt_d      = rd_cnt_q + NW'(1);
                    state_d       = ACK;
                end else begin
                    tmo_d   = CW'(READ_TIMEOUT);
                    state_d = RD_WAIT;
                end
`else
                tmo_d   = CW'(READ_TIMEOUT);
                state_d = RD_WAIT;
`endif
            end
            RD_WAIT: begin
                // Valid data beats a simultaneous timeout.
                if (core_rd_valid) begin
                    read_export_d = core_rdata;
                    state_d       = ACK;
`ifdef RESP_TXN_COUNT_EN
                    rd_cnt_d = rd_cnt_q + NW'(1);
`endif
                end else if (tmo_q == CW'(0)) begin
                    read_export_d = TIMEOUT_WORD;
                    err_d         = 1'b1;
                    state_d       = ACK;
                end else begin
                    tmo_d = tmo_q - CW'(1);
                end
            end
            ACK: begin
                if (!wr_s && !rd_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        core_wr_en_d = (state_d == WRITE);
        core_rd_en_d = (state_d == RD_ISSUE) && (state_q == IDLE) && !local_rd;
        ack_d        = (state_d == ACK);
        busy_d       = core_busy;
        done_d       = core_done || (done_q && !clr_done);
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q       <= IDLE;
            wr_sync_q     <= '0;
            rd_sync_q     <= '0;
            core_addr_q   <= '0;
            core_wdata_q  <= '0;
            read_export_q <= '0;
            core_wr_en_q  <= 1'b0;
            core_rd_en_q  <= 1'b0;
            ack_q         <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            tmo_q         <= '0;
`ifdef RESP_TXN_COUNT_EN
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            wr_sync_q     <= {wr_sync_q[SYNC_STAGES-2:0], control_export[0]};
            rd_sync_q     <= {rd_sync_q[SYNC_STAGES-2:0], control_export[1]};
            core_addr_q   <= core_addr_d;
            core_wdata_q  <= core_wdata_d;
            read_export_q <= read_export_d;
            core_wr_en_q  <= core_wr_en_d;
            core_rd_en_q  <= core_rd_en_d;
            ack_q         <= ack_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            tmo_q         <= tmo_d;
`ifdef RESP_TXN_COUNT_EN
            wr_cnt_q      <= wr_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_pio_bus_responder.sv
// Directed bench for pio_bus_responder (default parameters); covers RESP_TXN_COUNT_EN when defined.
module tb_pio_bus_responder;

    logic        clk;
    logic        rst_n;
    logic [7:0]  address;
    logic [31:0] wdata;
    logic [31:0] read_export;
    wire  [7:0]  control_export;
    logic [3:0]  host_ctrl;
    logic [7:0]  core_addr;
    logic [31:0] core_wdata;
    logic        core_wr_en, core_rd_en;
    logic [31:0] core_rdata;
    logic        core_rd_valid, core_busy, core_done;

    int n_chk = 0;
    int n_fail = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;
    int both_cnt = 0;
    int base_wr, base_rd, n;

    assign control_export[3:0] = host_ctrl;

    pio_bus_responder dut (
        .clk_clk        (clk),
        .reset_reset_n  (rst_n),
        .address_export (address),
        .write_export   (wdata),
        .read_export    (read_export),
        .control_export (control_export),
        .core_addr      (core_addr),
        .core_wdata     (core_wdata),
        .core_wr_en     (core_wr_en),
        .core_rd_en     (core_rd_en),
        .core_rdata     (core_rdata),
        .core_rd_valid  (core_rd_valid),
        .core_busy      (core_busy),
        .core_done      (core_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (core_wr_en) wr_pulses++;
        if (core_rd_en) rd_pulses++;
        if (core_wr_en && core_rd_en) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int cycles);
        for (int i = 0; i < cycles; i++) @(negedge clk);
    endtask

    task automatic start(input logic wr, input logic rd, input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        address   = a;
        wdata     = d;
        host_ctrl = {2'b00, rd, wr};
    endtask

    task automatic wait_ack(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (control_export[4]) break;
            @(negedge clk);
        end
        check(tag, 32'(control_export[4]), 32'd1);
    endtask

    task automatic wait_rd_en(input string tag);
        for (int i = 0; i < 10; i++) begin
            if (core_rd_en) break;
            @(negedge clk);
        end
        check(tag, 32'(core_rd_en), 32'd1);
    endtask

    task automatic finish_txn(input string tag);
        host_ctrl = 4'b0000;
        tick(3);
        check(tag, 32'(control_export[4]), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; address = '0; wdata = '0; host_ctrl = '0;
        core_rdata = '0; core_rd_valid = 1'b0; core_busy = 1'b0; core_done = 1'b0;
        tick(3);
        check("rst_status", 32'(control_export[7:4]), 32'h0);
        check("rst_read_export", read_export, 32'h0);
        check("rst_core_addr", 32'(core_addr), 32'h0);
        check("rst_core_wdata", core_wdata, 32'h0);
        check("rst_strobes", 32'({core_wr_en, core_rd_en}), 32'h0);
        rst_n = 1'b1;
        tick(2);

        // Write: wr_en at +1, ack at +2 from the first IDLE cycle with wr_s high
        base_wr = wr_pulses;
        start(1'b1, 1'b0, 8'h10, 32'h1234_5678);
        tick(2);
        check("wr_no_early_strobe", 32'(core_wr_en), 32'd0);
        tick(1);
        check("wr_strobe", 32'(core_wr_en), 32'd1);
        check("wr_core_addr", 32'(core_addr), 32'h10);
        check("wr_core_wdata", core_wdata, 32'h1234_5678);
        check("wr_ack_not_yet", 32'(control_export[4]), 32'd0);
        tick(1);
        check("wr_ack", 32'(control_export[4]), 32'd1);
        check("wr_strobe_single", 32'(core_wr_en), 32'd0);
        check("wr_err", 32'(control_export[5]), 32'd0);
        finish_txn("wr_ack_drop");
        check("wr_pulse_count", 32'(wr_pulses - base_wr), 32'd1);

        // Read with data three cycles after the strobe
        start(1'b0, 1'b1, 8'h20, 32'h0);
        wait_rd_en("rd_strobe");
        check("rd_core_addr", 32'(core_addr), 32'h20);
        tick(3);
        check("rd_ack_wait", 32'(control_export[4]), 32'd0);
        core_rdata = 32'hCAFE_0001; core_rd_valid = 1'b1;
        tick(1);
        core_rd_valid = 1'b0; core_rdata = 32'h0;
        check("rd_ack", 32'(control_export[4]), 32'd1);
        check("rd_data", read_export, 32'hCAFE_0001);
        check("rd_err", 32'(control_export[5]), 32'd0);
        finish_txn("rd_ack_drop");

        // Read timeout: ack READ_TIMEOUT+2 cycles after the strobe
        start(1'b0, 1'b1, 8'h30, 32'h0);
        wait_rd_en("tmo_strobe");
        n = 0;
        while (!control_export[4] && n < 400) begin
            tick(1);
            n++;
        end
        check("tmo_latency", 32'(n), 32'd257);
        check("tmo_data", read_export, 32'hDEAD_BEEF);
        check("tmo_err", 32'(control_export[5]), 32'd1);
        finish_txn("tmo_ack_drop");
        check("tmo_err_sticky", 32'(control_export[5]), 32'd1);
        start(1'b1, 1'b0, 8'h11, 32'h1);
        wait_ack("wr2_ack");
        check("wr2_err_cleared", 32'(control_export[5]), 32'd0);
        check("wr2_read_export_held", read_export, 32'hDEAD_BEEF);
        finish_txn("wr2_ack_drop");

        // Simultaneous wr_req and rd_req
        base_wr = wr_pulses; base_rd = rd_pulses;
        start(1'b1, 1'b1, 8'h40, 32'h5);
        wait_ack("both_ack");
        check("both_err", 32'(control_export[5]), 32'd1);
        finish_txn("both_ack_drop");
        check("both_no_strobes", 32'((wr_pulses - base_wr) + (rd_pulses - base_rd)), 32'd0);

        // Busy mirror
        core_busy = 1'b1;
        tick(1);
        check("busy_set", 32'(control_export[6]), 32'd1);
        core_busy = 1'b0;
        tick(1);
        check("busy_clr", 32'(control_export[6]), 32'd0);

        // Sticky done and CLR_ADDR clear
        core_done = 1'b1; tick(1); core_done = 1'b0; tick(1);
        check("done_set", 32'(control_export[7]), 32'd1);
        base_wr = wr_pulses;
        start(1'b1, 1'b0, 8'hFF, 32'h0);
        wait_ack("clr_ack");
        check("done_cleared", 32'(control_export[7]), 32'd0);
        finish_txn("clr_ack_drop");
        check("clr_no_wr_en", 32'(wr_pulses - base_wr), 32'd0);
        core_done = 1'b1; tick(1); core_done = 1'b0; tick(1);
        check("done_set2", 32'(control_export[7]), 32'd1);
        start(1'b1, 1'b0, 8'hFF, 32'h0);
        tick(2);
        core_done = 1'b1;
        tick(1);
        core_done = 1'b0;
        wait_ack("clr2_ack");
        check("done_set_wins", 32'(control_export[7]), 32'd1);
        finish_txn("clr2_ack_drop");

`ifdef RESP_TXN_COUNT_EN
        rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(2);
        for (int k = 0; k < 3; k++) begin
            start(1'b1, 1'b0, 8'h50, 32'(k));
            wait_ack("cnt_wr_ack");
            finish_txn("cnt_wr_drop");
        end
        base_rd = rd_pulses;
        start(1'b0, 1'b1, 8'hFE, 32'h0);
        wait_ack("cnt_rd_ack");
        check("cnt_value", read_export, 32'h0003_0000);
        finish_txn("cnt_rd_drop");
        check("cnt_no_rd_en", 32'(rd_pulses - base_rd), 32'd0);
`else
        start(1'b0, 1'b1, 8'hFE, 32'h0);
        wait_rd_en("fe_forwarded");
        check("fe_core_addr", 32'(core_addr), 32'hFE);
        tick(1);
        core_rdata = 32'h0BAD_F00D; core_rd_valid = 1'b1;
        tick(1);
        core_rd_valid = 1'b0;
        wait_ack("fe_ack");
        check("fe_data", read_export, 32'h0BAD_F00D);
        finish_txn("fe_ack_drop");
`endif

        // Reset during RD_WAIT
        start(1'b0, 1'b1, 8'h60, 32'h0);
        wait_rd_en("rst_rd_strobe");
        tick(1);
        rst_n = 1'b0;
        tick(1);
        check("midrst_ack", 32'(control_export[4]), 32'd0);
        check("midrst_read_export", read_export, 32'h0);
        check("midrst_strobes", 32'({core_wr_en, core_rd_en}), 32'h0);
        host_ctrl = 4'b0000;
        rst_n = 1'b1;
        tick(3);
        start(1'b1, 1'b0, 8'h12, 32'hA5A5_A5A5);
        wait_ack("post_rst_ack");
        check("post_rst_wdata", core_wdata, 32'hA5A5_A5A5);
        finish_txn("post_rst_drop");

        check("strobes_exclusive", 32'(both_cnt), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
